// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM operation arbiter.
package sdram_pkg;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned LEN_W     = 10;
  localparam int unsigned REF_CNT_W = 16;
  localparam int unsigned DEBT_W    = 4;
  localparam int unsigned TMO_W     = 10;

  localparam int unsigned REF_PERIOD_DEF   = 781;
  localparam int unsigned REF_MAX_PEND_DEF = 8;
  localparam int unsigned REF_URGENT_DEF   = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned GAP_CYCLES_DEF   = 2;
  localparam int unsigned OP_TIMEOUT_DEF   = 1023;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_REF  = 2'b11
  } op_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  typedef struct packed {
    op_type_e            kind;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    len;
  } op_desc_t;

  // Build the launch descriptor for a winner; refresh carries no address/length.
  function automatic op_desc_t pick_desc(
    input op_type_e          kind,
    input logic [ADDR_W-1:0] wa,
    input logic [LEN_W-1:0]  wl,
    input logic [ADDR_W-1:0] ra,
    input logic [LEN_W-1:0]  rl
  );
    op_desc_t d;
    d.kind = kind;
    d.addr = '0;
    d.len  = '0;
    if (kind == OP_WR) begin
      d.addr = wa;
      d.len  = wl;
    end else if (kind == OP_RD) begin
      d.addr = ra;
      d.len  = rl;
    end
    return d;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh tick generator and outstanding-refresh debt counter.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PERIOD   = REF_PERIOD_DEF,
  parameter int unsigned REF_MAX_PEND = REF_MAX_PEND_DEF
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              init_done,
  input  logic              ref_done,
  output logic [DEBT_W-1:0] debt,
  output logic              ref_overdue
);

  logic [REF_CNT_W-1:0] tick_cnt;
  logic                 tick_c;
  logic [DEBT_W-1:0]    debt_next;

  assign tick_c = init_done && (tick_cnt == REF_CNT_W'(REF_PERIOD - 1));

  // Debt next value: a tick and a completion on the same cycle cancel out.
  always_comb begin
    debt_next = debt;
    if (tick_c && !ref_done) begin
      if (debt != DEBT_W'(REF_MAX_PEND)) debt_next = debt + 1'b1;
    end else if (!tick_c && ref_done) begin
      if (debt != '0) debt_next = debt - 1'b1;
    end
  end

  // Period counter runs only once the SDRAM is initialised.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (init_done) begin
      tick_cnt <= tick_c ? '0 : tick_cnt + 1'b1;
    end
  end

  // Debt register and its saturation flag.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      debt        <= '0;
      ref_overdue <= 1'b0;
    end else begin
      debt        <= debt_next;
      ref_overdue <= (debt_next == DEBT_W'(REF_MAX_PEND));
    end
  end

endmodule

// File: rtl/sdram_op_arbiter.sv
// Serialises write, read and refresh requests onto the single SDRAM command engine.
module sdram_op_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PERIOD   = REF_PERIOD_DEF,
  parameter int unsigned REF_MAX_PEND = REF_MAX_PEND_DEF,
  parameter int unsigned REF_URGENT   = REF_URGENT_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int unsigned OP_TIMEOUT   = OP_TIMEOUT_DEF
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              op_start,
  output logic [1:0]        op_type,
  output logic [ADDR_W-1:0] op_addr,
  output logic [LEN_W-1:0]  op_len,
  input  logic              op_done,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic              busy,
  output logic              ref_overdue,
  output logic              op_timeout_err
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e              state;
  op_desc_t            desc;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [STREAK_W-1:0] streak;
  logic [DEBT_W-1:0]   debt;

  logic                expire_c;
  logic                finish_c;
  logic                ref_done_c;
  op_type_e            win_c;
  op_desc_t            desc_c;

  sdram_ref_timer #(
    .REF_PERIOD   (REF_PERIOD),
    .REF_MAX_PEND (REF_MAX_PEND)
  ) u_ref_timer (
    .clk_ref     (clk_ref),
    .rst         (rst),
    .init_done   (init_done),
    .ref_done    (ref_done_c),
    .debt        (debt),
    .ref_overdue (ref_overdue)
  );

  assign op_type = desc.kind;
  assign op_addr = desc.addr;
  assign op_len  = desc.len;

  // Completion: op_done wins over a same-cycle timeout expiry.
  always_comb begin
    expire_c   = (state == ST_RUN) && !op_done && (tmo_cnt == TMO_W'(OP_TIMEOUT));
    finish_c   = (state == ST_RUN) && (op_done || expire_c);
    ref_done_c = finish_c && (desc.kind == OP_REF);
  end

  // Fixed-priority arbitration with refresh urgency and read anti-starvation.
  always_comb begin
    win_c = OP_NONE;
    if (init_done) begin
      if (debt >= DEBT_W'(REF_URGENT)) begin
        win_c = OP_REF;
      end else if (wr_req && !((streak >= STREAK_W'(STARVE_LIMIT)) && rd_req)) begin
        win_c = OP_WR;
      end else if (rd_req) begin
        win_c = OP_RD;
      end else if (debt != '0) begin
        win_c = OP_REF;
      end
    end
    desc_c = pick_desc(win_c, wr_addr, wr_len, rd_addr, rd_len);
  end

  // Operation FSM with registered descriptor, grants, streak and timeout counters.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state          <= ST_IDLE;
      desc           <= '0;
      op_start       <= 1'b0;
      wr_grant       <= 1'b0;
      rd_grant       <= 1'b0;
      busy           <= 1'b0;
      op_timeout_err <= 1'b0;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
      streak         <= '0;
    end else begin
      op_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_c != OP_NONE) begin
            state    <= ST_RUN;
            op_start <= 1'b1;
            desc     <= desc_c;
            wr_grant <= (win_c == OP_WR);
            rd_grant <= (win_c == OP_RD);
            busy     <= 1'b1;
            tmo_cnt  <= '0;
            if (win_c == OP_RD) begin
              streak <= '0;
            end else if ((win_c == OP_WR) && rd_req && (streak < STREAK_W'(STARVE_LIMIT))) begin
              streak <= streak + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (finish_c) begin
            desc.kind <= OP_NONE;
            wr_grant  <= 1'b0;
            rd_grant  <= 1'b0;
            if (expire_c) op_timeout_err <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_op_arbiter.sv
// Self-checking bench for sdram_op_arbiter against a transaction-level reference model.
module tb_sdram_op_arbiter;

  localparam int REF_PERIOD   = 781;
  localparam int REF_MAX_PEND = 8;
  localparam int REF_URGENT   = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int GAP_CYCLES   = 2;
  localparam int OP_TIMEOUT   = 1023;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        wr_req = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [9:0]  wr_len = '0;
  logic        rd_req = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [9:0]  rd_len = '0;
  logic        op_done = 1'b0;
  logic        op_start;
  logic [1:0]  op_type;
  logic [23:0] op_addr;
  logic [9:0]  op_len;
  logic        wr_grant;
  logic        rd_grant;
  logic        busy;
  logic        ref_overdue;
  logic        op_timeout_err;

  int checks = 0;
  int errors = 0;

  sdram_op_arbiter #(
    .REF_PERIOD   (REF_PERIOD),
    .REF_MAX_PEND (REF_MAX_PEND),
    .REF_URGENT   (REF_URGENT),
    .STARVE_LIMIT (STARVE_LIMIT),
    .GAP_CYCLES   (GAP_CYCLES),
    .OP_TIMEOUT   (OP_TIMEOUT)
  ) dut (
    .clk_ref        (clk_ref),
    .rst            (rst),
    .init_done      (init_done),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_len         (wr_len),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_len         (rd_len),
    .op_start       (op_start),
    .op_type        (op_type),
    .op_addr        (op_addr),
    .op_len         (op_len),
    .op_done        (op_done),
    .wr_grant       (wr_grant),
    .rd_grant       (rd_grant),
    .busy           (busy),
    .ref_overdue    (ref_overdue),
    .op_timeout_err (op_timeout_err)
  );

  always #5 clk_ref = ~clk_ref;

  // Reference model: one operation in flight, identified by its launch edge.
  int          m_cyc = 0;
  int          m_init_cycles = 0;
  int          m_debt = 0;
  int          m_streak = 0;
  bit          m_active = 1'b0;
  int          m_kind = 0;
  int          m_launch = -10;
  int          m_idle_from = 0;
  logic [23:0] m_addr = '0;
  logic [9:0]  m_len = '0;
  bit          m_err = 1'b0;
  bit          m_tick, m_fin, m_expire;
  int          m_win;

  always @(posedge clk_ref) begin
    m_cyc++;
    if (rst) begin
      m_init_cycles = 0; m_debt = 0; m_streak = 0; m_active = 0; m_kind = 0;
      m_launch = -10; m_idle_from = m_cyc; m_addr = '0; m_len = '0; m_err = 0;
    end else begin
      m_tick = 0;
      if (init_done) begin
        m_init_cycles++;
        m_tick = (m_init_cycles % REF_PERIOD) == 0;
      end
      m_fin = 0; m_expire = 0;
      if (m_active) begin
        m_expire = !op_done && ((m_cyc - m_launch - 1) == OP_TIMEOUT);
        m_fin    = op_done || m_expire;
      end
      m_win = 0;
      if (!m_active && m_cyc > m_idle_from && init_done) begin
        if (m_debt >= REF_URGENT) m_win = 3;
        else if (wr_req && !(m_streak >= STARVE_LIMIT && rd_req)) m_win = 1;
        else if (rd_req) m_win = 2;
        else if (m_debt > 0) m_win = 3;
      end
      if (m_tick && !(m_fin && m_kind == 3)) m_debt = (m_debt < REF_MAX_PEND) ? m_debt + 1 : REF_MAX_PEND;
      else if (!m_tick && m_fin && m_kind == 3) m_debt = (m_debt > 0) ? m_debt - 1 : 0;
      if (m_fin) begin
        m_active = 0;
        if (m_expire) m_err = 1;
        m_idle_from = m_cyc + GAP_CYCLES;
      end
      if (m_win != 0) begin
        m_active = 1; m_kind = m_win; m_launch = m_cyc;
        m_addr = (m_win == 1) ? wr_addr : (m_win == 2) ? rd_addr : 24'h0;
        m_len  = (m_win == 1) ? wr_len  : (m_win == 2) ? rd_len  : 10'h0;
        if (m_win == 1 && rd_req && m_streak < STARVE_LIMIT) m_streak++;
        if (m_win == 2) m_streak = 0;
      end
    end
  end

  logic [41:0] obs;
  assign obs = {op_start, op_type, op_addr, op_len, wr_grant, rd_grant, busy, ref_overdue, op_timeout_err};

  function automatic logic [41:0] expv();
    logic [1:0] t;
    t = m_active ? 2'(m_kind) : 2'b00;
    return {(m_active && m_launch == m_cyc), t, m_addr, m_len, (m_active && m_kind == 1),
            (m_active && m_kind == 2), (m_active || m_cyc < m_idle_from), (m_debt == REF_MAX_PEND), m_err};
  endfunction

  task automatic do_reset();
    rst = 1; init_done = 0; wr_req = 0; rd_req = 0; op_done = 0;
    @(negedge clk_ref);
    @(negedge clk_ref);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 42'h0) begin errors++; $display("FAIL reset_zero: got %h want 0", obs); end
    wr_req = 1; rd_req = 1; wr_addr = 24'h123456; rd_addr = 24'h654321;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL init_low cyc %0d: got %h want %h", i, obs, expv()); end
    end
    wr_req = 0; rd_req = 0; init_done = 1;
    for (int i = 1; i <= 781; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL timer_start cyc %0d: got %h want %h", i, obs, expv()); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timer_paused_busy: got %b want 0", busy); end
    @(negedge clk_ref); checks++;
    if (op_start !== 1'b1 || op_type !== 2'b11) begin
      errors++; $display("FAIL first_refresh: got start=%b type=%b want 1/11", op_start, op_type);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    init_done = 1; wr_req = 1; wr_addr = 24'hABCDEF; wr_len = 10'd77;
    repeat (3) @(negedge clk_ref);
    rst = 1;
    @(negedge clk_ref); checks++;
    if (obs !== 42'h0) begin errors++; $display("FAIL reset_mid_op: got %h want 0", obs); end
    rst = 0; wr_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL after_reset cyc %0d: got %h want %h", i, obs, expv()); end
    end
  endtask

  task automatic test_write_only();
    do_reset();
    init_done = 1; wr_req = 1; wr_addr = 24'h000100; wr_len = 10'd512; rd_req = 0;
    @(negedge clk_ref); checks++;
    if (obs !== expv()) begin errors++; $display("FAIL wr_launch: got %h want %h", obs, expv()); end
    checks++; if (op_start !== 1'b1) begin errors++; $display("FAIL wr_op_start: got %b want 1", op_start); end
    checks++; if (op_type !== 2'b01) begin errors++; $display("FAIL wr_op_type: got %b want 01", op_type); end
    checks++; if (op_addr !== 24'h000100) begin errors++; $display("FAIL wr_op_addr: got %h want 000100", op_addr); end
    checks++; if (op_len !== 10'd512) begin errors++; $display("FAIL wr_op_len: got %0d want 512", op_len); end
    checks++; if (wr_grant !== 1'b1) begin errors++; $display("FAIL wr_grant_on: got %b want 1", wr_grant); end
    wr_req = 0;
    for (int i = 1; i < 600; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL wr_run cyc %0d: got %h want %h", i, obs, expv()); end
    end
    op_done = 1;
    @(negedge clk_ref); op_done = 0; checks++;
    if (wr_grant !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_done: got grant=%b busy=%b want 0/1", wr_grant, busy);
    end
    @(negedge clk_ref); checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_gap2: got busy=%b want 1", busy); end
    @(negedge clk_ref); checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_gap_end: got busy=%b want 0", busy); end
  endtask

  task automatic test_starvation();
    string seq;
    int    age, nops;
    seq = ""; age = -1; nops = 0;
    do_reset();
    init_done = 1; wr_req = 1; rd_req = 1;
    for (int i = 0; i < 1000 && nops < 10; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL starve cyc %0d: got %h want %h", i, obs, expv()); end
      op_done = 0;
      if (op_start) begin
        seq = {seq, wr_grant ? "W" : (rd_grant ? "R" : "X")};
        nops++; age = 0;
      end else if (age >= 0) age++;
      if (age == 10) begin op_done = 1; age = -1; end
    end
    op_done = 0; wr_req = 0; rd_req = 0;
    checks++;
    if (seq != "WWWWRWWWWR") begin errors++; $display("FAIL starve_seq: got %s want WWWWRWWWWR", seq); end
  endtask

  task automatic test_refresh_urgency();
    int  age, lat;
    bit  waiting_ref, waiting_wr;
    age = -1; lat = 1000; waiting_ref = 0; waiting_wr = 0;
    do_reset();
    init_done = 1; wr_addr = 24'h0F0F0F; wr_len = 10'd33;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL urgency cyc %0d: got %h want %h", i, obs, expv()); end
      op_done = 0;
      if (op_start) begin
        age = 0;
        if (waiting_ref) begin
          checks++;
          if (op_type !== 2'b11) begin errors++; $display("FAIL urgent_ref_first: got %b want 11", op_type); end
          waiting_ref = 0; waiting_wr = 1; lat = 5;
        end else if (waiting_wr && wr_grant) begin
          waiting_wr = 0;
          break;
        end
      end else if (age >= 0) age++;
      if (age == lat) begin op_done = 1; age = -1; end
      if (!waiting_ref && !waiting_wr && m_debt >= REF_URGENT + 1) begin
        wr_req = 1; waiting_ref = 1;
      end
    end
    op_done = 0; wr_req = 0;
    checks++;
    if (waiting_ref || waiting_wr || wr_req !== 1'b0 || !m_active) begin
      if (waiting_ref || waiting_wr) begin errors++; $display("FAIL urgency_bound: sequence did not complete (ref=%0d wr=%0d)", waiting_ref, waiting_wr); end
    end
  endtask

  task automatic test_saturation();
    bit seen;
    seen = 0;
    do_reset();
    init_done = 1;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL saturate cyc %0d: got %h want %h", i, obs, expv()); end
      seen = (ref_overdue === 1'b1);
    end
    checks++;
    if (ref_overdue !== 1'b1) begin errors++; $display("FAIL overdue: got %b want 1", ref_overdue); end
    checks++;
    if (op_timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", op_timeout_err); end
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL overdue_hold cyc %0d: got %h want %h", i, obs, expv()); end
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    init_done = 1; wr_req = 1; wr_addr = 24'($urandom); wr_len = 10'($urandom);
    @(negedge clk_ref); wr_req = 0;
    for (int j = 1; j <= 1023; j++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL tmo_edge cyc %0d: got %h want %h", j, obs, expv()); end
    end
    op_done = 1;
    @(negedge clk_ref); op_done = 0; checks++;
    if (op_timeout_err !== 1'b0 || wr_grant !== 1'b0) begin
      errors++; $display("FAIL done_at_limit: got err=%b grant=%b want 0/0", op_timeout_err, wr_grant);
    end
    do_reset();
    init_done = 1; wr_req = 1;
    @(negedge clk_ref); wr_req = 0;
    for (int j = 1; j <= 1023; j++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL tmo_force cyc %0d: got %h want %h", j, obs, expv()); end
    end
    checks++;
    if (wr_grant !== 1'b1 || op_timeout_err !== 1'b0) begin
      errors++; $display("FAIL tmo_early: got grant=%b err=%b want 1/0", wr_grant, op_timeout_err);
    end
    @(negedge clk_ref); checks++;
    if (wr_grant !== 1'b0 || op_timeout_err !== 1'b1) begin
      errors++; $display("FAIL tmo_expire: got grant=%b err=%b want 0/1", wr_grant, op_timeout_err);
    end
  endtask

  task automatic test_random();
    int age, target;
    age = -1; target = -1;
    do_reset();
    init_done = 1;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk_ref); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs, expv()); end
      rst = ($urandom % 3000) == 0;
      if (($urandom % 400) == 0) init_done = ~init_done;
      if (($urandom % 8) == 0) wr_req = ~wr_req;
      if (($urandom % 8) == 0) rd_req = ~rd_req;
      wr_addr = 24'($urandom); wr_len = 10'($urandom);
      rd_addr = 24'($urandom); rd_len = 10'($urandom);
      if (op_start) begin
        age = 0;
        target = (($urandom % 40) == 0) ? -1 : int'($urandom_range(0, 30));
      end else if (age >= 0) age++;
      op_done = (age >= 0 && age == target) || (($urandom % 64) == 0);
      if (rst) age = -1;
    end
    rst = 0; op_done = 0; wr_req = 0; rd_req = 0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_write_only();
    test_starvation();
    test_timeout_boundary();
    test_refresh_urgency();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
